diff_clk_out_ctrl: RTL

Run/stop sequencer for the Zybo differential clock outputs: gates the 80 MHz and 160 MHz OBUFDS feeds through clock-enable buffers (BUFGCE) after the clock wizard reports lock. Runs in the 320 MHz domain. Debounces the board switch SW into start/stop toggles, enables 80 MHz before 160 MHz, and disables them in reverse order. Forces both outputs off whenever MMCM lock is lost.

---
 rtl/diff_clk_pkg.sv | 21 ++
 rtl/sw_debounce.sv | 67 ++++++
 rtl/diff_clk_out_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/diff_clk_pkg.sv
// Shared types for the differential clock output sequencer.
//   state_e   : FSM state encodings (0..5, visible on state_out)
//   cnt_width : width of a counter that must reach max(a, b) - 1
package diff_clk_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        READY     = 3'd2,
        START80   = 3'd3,
        RUN       = 3'd4,
        STOP160   = 3'd5
    } state_e;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Board switch conditioner: 2-FF synchronizer, stability debounce and a
// one-cycle toggle pulse on each debounced rising edge.
//   clk_i    : 320 MHz block clock
//   rst_i    : asynchronous active-high reset
//   sw_i     : raw switch, asynchronous
//   sw_db_o  : debounced switch level
//   toggle_o : 1-cycle pulse, one cycle after sw_db_o rises
module sw_debounce
    import diff_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3200000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic sw_db_o,
    output logic toggle_o
);

    localparam int             DB_W    = cnt_width(DEBOUNCE_CYCLES, 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sw_meta_q;
    logic            sw_s_q;
    logic            sw_db_q;
    logic            sw_db_d;
    logic            sw_db_dly_q;
    logic            toggle_q;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // Any sample equal to the current debounced level restarts the count,
    // so only an uninterrupted run of differing samples flips sw_db.
    always_comb begin
        sw_db_d = sw_db_q;
        cnt_d   = '0;
        if (sw_s_q != sw_db_q) begin
            if (cnt_q == DB_LAST) begin
                sw_db_d = sw_s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_meta_q   <= 1'b0;
            sw_s_q      <= 1'b0;
            sw_db_q     <= 1'b0;
            sw_db_dly_q <= 1'b0;
            toggle_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sw_meta_q   <= sw_i;
            sw_s_q      <= sw_meta_q;
            sw_db_q     <= sw_db_d;
            sw_db_dly_q <= sw_db_q;
            toggle_q    <= sw_db_q & ~sw_db_dly_q;
            cnt_q       <= cnt_d;
        end
    end

    assign sw_db_o  = sw_db_q;
    assign toggle_o = toggle_q;

endmodule

// File: rtl/diff_clk_out_ctrl.sv
// Run/stop sequencer for the 80 MHz and 160 MHz differential clock outputs.
// Waits for a settled MMCM lock, then a debounced switch toggle starts the
// outputs (80 MHz first, 160 MHz after a stagger) and a second toggle stops
// them in reverse order. Loss of lock forces everything off.
//   clk_320MHz : block clock
//   rst        : asynchronous active-high reset
//   locked     : MMCM lock, asynchronous
//   SW         : raw board switch, asynchronous
//   en_80MHz   : BUFGCE enable, 80 MHz output (registered)
//   en_160MHz  : BUFGCE enable, 160 MHz output (registered)
//   running    : high only in RUN
//   state_out  : current state encoding
//   run_count  : number of RUN entries, wraps at 255
//
// state     | meaning
// WAIT_LOCK | outputs off, waiting for synchronized lock
// SETTLE    | lock seen, waiting SETTLE_CYCLES for it to stay stable
// READY     | outputs off, waiting for a start toggle
// START80   | 80 MHz enabled, waiting STAGGER_CYCLES before 160 MHz
// RUN       | both outputs enabled, waiting for a stop toggle
// STOP160   | 160 MHz disabled, waiting STAGGER_CYCLES before 80 MHz off
module diff_clk_out_ctrl
    import diff_clk_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 1024,
    parameter int DEBOUNCE_CYCLES = 3200000,
    parameter int STAGGER_CYCLES  = 16
) (
    input  logic       clk_320MHz,
    input  logic       rst,
    input  logic       locked,
    input  logic       SW,
    output logic       en_80MHz,
    output logic       en_160MHz,
    output logic       running,
    output logic [2:0] state_out,
    output logic [7:0] run_count
);

    localparam int              CNT_W        = cnt_width(SETTLE_CYCLES, STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    logic             locked_meta_q;
    logic             locked_s_q;
    logic             toggle;
    logic             sw_db;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timed_state;
    logic [7:0]       run_count_q;
    logic [7:0]       run_count_d;
    logic             en_80_q;
    logic             en_80_d;
    logic             en_160_q;
    logic             en_160_d;
    logic             running_q;
    logic             running_d;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk_i    (clk_320MHz),
        .rst_i    (rst),
        .sw_i     (SW),
        .sw_db_o  (sw_db),
        .toggle_o (toggle)
    );

    always_ff @(posedge clk_320MHz or posedge rst) begin
        if (rst) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
        end else begin
            locked_meta_q <= locked;
            locked_s_q    <= locked_meta_q;
        end
    end

    // Lock loss overrides everything; toggles outside READY/RUN fall through
    // the case unused, which is what drops them.
    always_comb begin
        state_d = state_q;
        if (!locked_s_q) begin
            state_d = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: state_d = SETTLE;
                SETTLE:    if (cnt_q == SETTLE_LAST)  state_d = READY;
                READY:     if (toggle)                state_d = START80;
                START80:   if (cnt_q == STAGGER_LAST) state_d = RUN;
                RUN:       if (toggle)                state_d = STOP160;
                STOP160:   if (cnt_q == STAGGER_LAST) state_d = READY;
                default:   state_d = WAIT_LOCK;
            endcase
        end
    end

    // Outputs decode state_d so they register on the same edge as state_q.
    always_comb begin
        timed_state = (state_d == SETTLE) || (state_d == START80) || (state_d == STOP160);
        cnt_d       = (timed_state && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
        run_count_d = ((state_d == RUN) && (state_q != RUN)) ? run_count_q + 8'd1 : run_count_q;
        en_80_d     = (state_d == START80) || (state_d == RUN) || (state_d == STOP160);
        en_160_d    = (state_d == RUN);
        running_d   = (state_d == RUN);
    end

    always_ff @(posedge clk_320MHz or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            run_count_q <= '0;
            en_80_q     <= 1'b0;
            en_160_q    <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_count_q <= run_count_d;
            en_80_q     <= en_80_d;
            en_160_q    <= en_160_d;
            running_q   <= running_d;
        end
    end

    assign en_80MHz  = en_80_q;
    assign en_160MHz = en_160_q;
    assign running   = running_q;
    assign state_out = state_q;
    assign run_count = run_count_q;

endmodule
